// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NRD_DEF    = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by wr1.
module regfile_scoreboard import regfile_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   input  logic                  wr1_fire,
   input  logic [ADDR_W-1:0]     wr1_addr,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD-1:0]        rd_busy,
   output logic                  busy_any
);
   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0] busy;
   logic            iss_fire;

   assign iss_ready = !busy[iss_addr];
   assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
   assign busy_any  = |busy;

   // Set is applied after clear so a same-cycle issue keeps the bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (wr1_fire) busy[wr1_addr] <= 1'b0;
         if (iss_fire) busy[iss_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rdb
      logic [ADDR_W-1:0] a;
      assign a          = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_busy[i] = busy[a] && !(wr1_fire && wr1_addr == a);
   end
endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, zero-latency bypass and a WAW scoreboard.
module regfile_sb import regfile_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr0_en,
   input  logic [ADDR_W-1:0]     wr0_addr,
   input  logic [DATA_W-1:0]     wr0_data,
   input  logic                  wr1_valid,
   input  logic [ADDR_W-1:0]     wr1_addr,
   input  logic [DATA_W-1:0]     wr1_data,
   output logic                  wr1_ready,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  iss_ready,
   output logic                  busy_any
);
   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] mem [NREG];
   logic              wr1_fire;

   // wr0 owns the register on a same-address collision; wr1 retries next cycle.
   assign wr1_ready = !(wr0_en && wr0_addr == wr1_addr && wr1_addr != '0);
   assign wr1_fire  = wr1_valid && wr1_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) mem[r] <= '0;
      end else begin
         if (wr1_fire && wr1_addr != '0) mem[wr1_addr] <= wr1_data;
         if (wr0_en && wr0_addr != '0)   mem[wr0_addr] <= wr0_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      assign a = rd_addr[i*ADDR_W +: ADDR_W];
      always_comb begin
         d = mem[a];
         if (a == '0)                          d = '0;
         else if (wr0_en && wr0_addr == a)     d = wr0_data;
         else if (wr1_fire && wr1_addr == a)   d = wr1_data;
      end
      assign rd_data[i*DATA_W +: DATA_W] = d;
   end

   regfile_scoreboard #(.ADDR_W(ADDR_W), .NRD(NRD)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .iss_ready (iss_ready),
      .wr1_fire  (wr1_fire),
      .wr1_addr  (wr1_addr),
      .rd_addr   (rd_addr),
      .rd_busy   (rd_busy),
      .busy_any  (busy_any)
   );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;
   localparam int DW = 32, AW = 5, NRD = 2;

   logic              clk = 0;
   logic              reset;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              wr0_en;
   logic [AW-1:0]     wr0_addr;
   logic [DW-1:0]     wr0_data;
   logic              wr1_valid;
   logic [AW-1:0]     wr1_addr;
   logic [DW-1:0]     wr1_data;
   logic              wr1_ready;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic              iss_ready;
   logic              busy_any;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready), .busy_any(busy_any)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] rdd(input int p);
      return rd_data[p*DW +: DW];
   endfunction

   task automatic idle();
      wr0_en = 0; wr1_valid = 0; iss_valid = 0;
   endtask

   initial begin
      reset = 1; rd_addr = '0; idle();
      wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; iss_addr = '0;
      step(); step();
      reset = 0;
      rd(0, 5); rd(1, 9); iss_addr = 9; #1;
      chk("rst_rd0", rdd(0), 0);
      chk("rst_rd1", rdd(1), 0);
      chk("rst_rdbusy", rd_busy, 0);
      chk("rst_busyany", busy_any, 0);
      chk("rst_wr1rdy", wr1_ready, 1);
      chk("rst_issrdy", iss_ready, 1);

      // basic write, r0 hardwired
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234_5678;
      step(); idle(); #1;
      chk("r5_stored", rdd(0), 32'h1234_5678);
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF; rd(0, 0); #1;
      chk("r0_bypass", rdd(0), 0);
      step(); idle(); #1;
      chk("r0_stored", rdd(0), 0);

      // wr0 bypass
      wr0_en = 1; wr0_addr = 7; wr0_data = 32'hA; rd(1, 7); #1;
      chk("r7_bypass", rdd(1), 32'hA);
      step(); idle(); #1;
      chk("r7_stored", rdd(1), 32'hA);

      // wr0/wr1 collision
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
      wr1_valid = 1; wr1_addr = 3; wr1_data = 32'h22; rd(0, 3); #1;
      chk("coll_wr1rdy", wr1_ready, 0);
      chk("coll_rd", rdd(0), 32'h11);
      step(); wr0_en = 0; #1;
      chk("retry_wr1rdy", wr1_ready, 1);
      chk("retry_bypass", rdd(0), 32'h22);
      step(); idle(); #1;
      chk("r3_stored", rdd(0), 32'h22);

      // both ports to different addresses
      wr0_en = 1; wr0_addr = 10; wr0_data = 32'hAA;
      wr1_valid = 1; wr1_addr = 11; wr1_data = 32'hBB; #1;
      chk("dual_wr1rdy", wr1_ready, 1);
      step(); idle(); rd(0, 10); rd(1, 11); #1;
      chk("dual_r10", rdd(0), 32'hAA);
      chk("dual_r11", rdd(1), 32'hBB);

      // issue / writeback on r9
      iss_valid = 1; iss_addr = 9; rd(0, 9); #1;
      chk("iss9_rdy", iss_ready, 1);
      step(); idle(); #1;
      chk("iss9_busyany", busy_any, 1);
      chk("iss9_rdbusy", rd_busy[0], 1);
      iss_valid = 1; #1;
      chk("iss9_waw", iss_ready, 0);
      iss_valid = 0; wr1_valid = 1; wr1_addr = 9; wr1_data = 32'h55; #1;
      chk("wb9_rdbusy", rd_busy[0], 0);
      chk("wb9_bypass", rdd(0), 32'h55);
      step(); idle(); #1;
      chk("wb9_busyany", busy_any, 0);
      chk("wb9_stored", rdd(0), 32'h55);

      // same-cycle issue and clear: set wins
      iss_valid = 1; iss_addr = 4; wr1_valid = 1; wr1_addr = 4; wr1_data = 32'h44; rd(1, 4);
      step(); idle(); #1;
      chk("setwins_rdbusy", rd_busy[1], 1);
      chk("setwins_data", rdd(1), 32'h44);
      wr1_valid = 1; wr1_addr = 4; wr1_data = 32'h45;
      step(); idle(); #1;
      chk("r4_clear", busy_any, 0);

      // wr0 into busy register keeps busy bit
      iss_valid = 1; iss_addr = 6; step(); idle();
      wr0_en = 1; wr0_addr = 6; wr0_data = 32'h66; rd(0, 6);
      step(); idle(); #1;
      chk("wr0busy_data", rdd(0), 32'h66);
      chk("wr0busy_bit", rd_busy[0], 1);

      // reset mid-operation; writes in the reset cycle are discarded
      iss_valid = 1; iss_addr = 2; step(); idle();
      wr0_en = 1; wr0_addr = 2; wr0_data = 32'h77; step(); idle();
      rd(1, 2); #1;
      chk("r2_pre", rdd(1), 32'h77);
      reset = 1; wr0_en = 1; wr0_addr = 8; wr0_data = 32'h88; iss_valid = 1; iss_addr = 12;
      step(); reset = 0; idle(); rd(0, 6); iss_addr = 2; #1;
      chk("mid_r6", rdd(0), 0);
      chk("mid_r2", rdd(1), 0);
      chk("mid_busyany", busy_any, 0);
      chk("mid_rdbusy", rd_busy, 0);
      chk("mid_issrdy", iss_ready, 1);
      rd(0, 8); #1;
      chk("mid_r8_discard", rdd(0), 0);
      iss_addr = 12; #1;
      chk("mid_iss12", iss_ready, 1);

      // late wr1 after reset is a plain write
      wr1_valid = 1; wr1_addr = 2; wr1_data = 32'h99;
      step(); idle(); #1;
      chk("late_wr1", rdd(1), 32'h99);
      chk("late_busyany", busy_any, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; NREG = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rd_addr  input  NRD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  NRD*DATA_W  read data, same slicing.
REQ-008 SHALL have port rd_busy  output  NRD  per-port pending-write flag.
REQ-009 SHALL have ports wr0_en, wr0_addr, wr0_data  input  1/ADDR_W/DATA_W  pipeline writeback port, highest priority.
REQ-010 SHALL have ports wr1_valid, wr1_addr, wr1_data  input  1/ADDR_W/DATA_W  long-latency unit writeback port.
REQ-011 SHALL have port wr1_ready  output  1  wr1 accept; transfer when wr1_valid && wr1_ready.
REQ-012 SHALL have ports iss_valid, iss_addr  input  1/ADDR_W  marks a register pending a wr1 result.
REQ-013 SHALL have port iss_ready  output  1  issue accept; issue when iss_valid && iss_ready.
REQ-014 SHALL have port busy_any  output  1  OR of all scoreboard bits.

Function
REQ-015 SHALL store NREG x DATA_W registers; register 0 always reads 0; writes to it are ignored.
REQ-016 SHALL commit wr0 writes at the rising clk edge when wr0_en and wr0_addr != 0.
REQ-017 SHALL drive wr1_ready = !(wr0_en && wr0_addr == wr1_addr && wr1_addr != 0), combinationally.
REQ-018 SHALL commit an accepted wr1 write at the same edge; wr0 and wr1 to different addresses both commit.
REQ-019 SHALL bypass combinationally (zero latency): rd_data[i] = wr0_data if wr0_en and addresses match; else wr1_data if the wr1 transfer is accepted and addresses match; else stored value. Address 0 SHALL return 0.
REQ-020 SHALL keep one scoreboard bit per register, never set for register 0.
REQ-021 SHALL drive iss_ready = !busy[iss_addr] (WAW stall); iss_addr 0 is always ready and does nothing.
REQ-022 SHALL set busy[iss_addr] at the edge of an accepted issue.
REQ-023 SHALL clear busy[wr1_addr] at the edge of an accepted wr1 transfer.
REQ-024 SHALL, when issue and wr1 clear target the same register in one cycle, leave the bit set (set wins).
REQ-025 SHALL drive rd_busy[i] = busy[rd_addr[i]] && !(accepted wr1 to rd_addr[i] this cycle).
REQ-026 SHALL let wr0 write a busy register normally, leaving its busy bit unchanged.
REQ-027 SHALL accept a wr1 transfer to a non-busy register as a plain write.

Reset
REQ-028 SHALL, at a rising edge with reset high, clear all registers and scoreboard bits; writes and issues in that cycle are discarded.
REQ-029 SHALL, after reset, present rd_data = 0, rd_busy = 0, busy_any = 0, wr1_ready = 1 (absent wr0 conflict), iss_ready = 1.
REQ-030 SHALL abandon pending scoreboard state on reset mid-operation; a late wr1 then acts as a plain write.

Structure
REQ-031 SHALL take default parameter constants DATA_W/ADDR_W/NRD from shared package regfile_pkg.
REQ-032 SHALL implement the scoreboard (set/clear/ready/busy logic) as sub-module regfile_scoreboard; storage and bypass stay in the top.

Verification
REQ-033 SHALL cover: reset, then wr0 r5=0x1234_5678; next cycle read r5 -> 0x1234_5678; read r0 -> 0 after wr0 r0=0xFFFF_FFFF.
REQ-034 SHALL cover: wr0 r7=0xA and read r7 in the same cycle -> rd_data 0xA (bypass); next cycle stored 0xA.
REQ-035 SHALL cover: wr0 r3=0x11 with wr1 r3=0x22 -> wr1_ready 0, r3=0x11; next cycle wr1 accepted -> r3=0x22.
REQ-036 SHALL cover: issue r9 -> busy_any 1, rd_busy 1 for r9, second issue r9 iss_ready 0; wr1 r9=0x55 -> same-cycle rd_busy 0, rd_data 0x55; next cycle busy_any 0.
REQ-037 SHALL cover: issue r4 with wr1 r4 in the same cycle -> busy[r4] stays 1.
REQ-038 SHALL cover: issue r2, r2=0x77, assert reset -> all reads 0, busy_any 0, iss_ready 1.
